// File: rtl/pcu_backup_ctrl.sv
// Power-control backup unit: periodic dirty-register scan into a FIFO toward NVM, with emergency flush on power-off.
// Optional PCU_FASTSCAN_EN: priority-encoded jump to the next dirty index instead of a linear scan.
module pcu_backup_ctrl #(
  parameter int NUM_REGS    = 16,
  parameter int DATA_W      = 32,
  parameter int BUF_DEPTH   = 8,
  parameter int POLL_PERIOD = 1000,
  parameter int IDX_W       = $clog2(NUM_REGS),
  parameter int LVL_W       = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic                    Pwr_off,
  input  logic [NUM_REGS-1:0]     Reg_Dirty,
  output logic [IDX_W-1:0]        Reg_Sel,
  input  logic [DATA_W-1:0]       Reg_Data,
  output logic                    Clr_Dirty,
  output logic                    Out_Valid,
  output logic [IDX_W+DATA_W-1:0] Out_Data,
  input  logic                    Out_Ready,
  output logic [LVL_W-1:0]        Buf_Level,
  output logic                    Busy,
  output logic                    Flush_Done
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int ENT_W = IDX_W + DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(POLL_PERIOD - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(BUF_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT, S_POLL, S_CAPTURE, S_FLUSH, S_FCAPT, S_DRAIN, S_HALT
  } state_t;

  state_t           r_state, w_stateNext;
  logic [IDX_W-1:0] r_idx, w_idxNext;
  logic [TMR_W-1:0] r_timer, w_timerNext;
  logic [ENT_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [LVL_W-1:0] r_level;
  logic             w_full, w_capState, w_push, w_pop, w_isLast;

  assign w_full     = (r_level == FULL_LVL);
  assign w_capState = (r_state == S_CAPTURE) || (r_state == S_FCAPT);
  assign w_push     = w_capState && !w_full;
  assign w_pop      = (r_level != '0) && Out_Ready;
  assign w_isLast   = (r_idx == LAST_IDX);

`ifdef PCU_FASTSCAN_EN
  logic [NUM_REGS-1:0] w_masked;
  logic [IDX_W-1:0]    w_hitIdx;

  assign w_masked = Reg_Dirty & ({NUM_REGS{1'b1}} << r_idx);

  always_comb begin
    w_hitIdx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (w_masked[i]) w_hitIdx = IDX_W'(i);
    end
  end
`endif

  // POLL/CAPTURE and FLUSH/FCAPT share one scan; only the exit target differs.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_timerNext = r_timer;
    case (r_state)
      S_IDLE: if (Start) w_stateNext = S_ARM;
      S_ARM: begin
        w_idxNext   = '0;
        w_timerNext = '0;
        if (!w_full) w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (r_timer == LAST_TICK) w_stateNext = S_POLL;
        else w_timerNext = r_timer + TMR_W'(1);
      end
      S_POLL, S_FLUSH: begin
`ifdef PCU_FASTSCAN_EN
        if (|w_masked) begin
          w_idxNext   = w_hitIdx;
          w_stateNext = (r_state == S_POLL) ? S_CAPTURE : S_FCAPT;
        end else begin
          w_idxNext   = '0;
          w_stateNext = (r_state == S_POLL) ? S_ARM : S_DRAIN;
        end
`else
        if (Reg_Dirty[r_idx]) begin
          w_stateNext = (r_state == S_POLL) ? S_CAPTURE : S_FCAPT;
        end else if (w_isLast) begin
          w_idxNext   = '0;
          w_stateNext = (r_state == S_POLL) ? S_ARM : S_DRAIN;
        end else begin
          w_idxNext = r_idx + IDX_W'(1);
        end
`endif
      end
      S_CAPTURE, S_FCAPT: begin
        if (!w_full) begin
          if (w_isLast) begin
            w_idxNext   = '0;
            w_stateNext = (r_state == S_CAPTURE) ? S_ARM : S_DRAIN;
          end else begin
            w_idxNext   = r_idx + IDX_W'(1);
            w_stateNext = (r_state == S_CAPTURE) ? S_POLL : S_FLUSH;
          end
        end
      end
      S_DRAIN: if (r_level == '0) w_stateNext = S_HALT;
      S_HALT: w_stateNext = S_HALT;
      default: w_stateNext = S_IDLE;
    endcase
    // Power loss overrides any normal-mode transition; a push committed this cycle still lands.
    if (Pwr_off && (r_state inside {S_IDLE, S_ARM, S_WAIT, S_POLL, S_CAPTURE})) begin
      w_stateNext = S_FLUSH;
      w_idxNext   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_timer <= w_timerNext;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= {r_idx, Reg_Data};
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign Reg_Sel    = r_idx;
  assign Clr_Dirty  = w_push;
  assign Out_Valid  = (r_level != '0);
  assign Out_Data   = r_mem[r_rdPtr];
  assign Buf_Level  = r_level;
  assign Busy       = (r_state != S_IDLE) && (r_state != S_HALT);
  assign Flush_Done = (r_state == S_HALT);

endmodule

// File: tb/tb_pcu_backup_ctrl.sv
// Self-checking bench for pcu_backup_ctrl (NUM_REGS=4, BUF_DEPTH=2, POLL_PERIOD=4) with a behavioural register bank.
module tb_pcu_backup_ctrl;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BD = 2;
  localparam int PP = 4;
  localparam int IW = 2;
  localparam int LW = 2;
`ifdef PCU_FASTSCAN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst, Start, Pwr_off, Out_Ready;
  logic [NR-1:0] Reg_Dirty;
  logic [IW-1:0] Reg_Sel;
  logic [DW-1:0] Reg_Data;
  logic Clr_Dirty, Out_Valid, Busy, Flush_Done;
  logic [IW+DW-1:0] Out_Data;
  logic [LW-1:0] Buf_Level;

  logic [NR-1:0] dirty;
  logic [DW-1:0] bankData [NR];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clrCyc[$];
  int clrSel[$];
  logic [IW+DW-1:0] popData[$];
  logic holdPrev = 1'b0;
  logic [IW+DW-1:0] dataPrev;

  assign Reg_Dirty = dirty;
  assign Reg_Data  = bankData[Reg_Sel];

  always #5 Clk = ~Clk;

  pcu_backup_ctrl #(
    .NUM_REGS(NR), .DATA_W(DW), .BUF_DEPTH(BD), .POLL_PERIOD(PP)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pwr_off(Pwr_off),
    .Reg_Dirty(Reg_Dirty), .Reg_Sel(Reg_Sel), .Reg_Data(Reg_Data),
    .Clr_Dirty(Clr_Dirty), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Out_Ready(Out_Ready), .Buf_Level(Buf_Level), .Busy(Busy), .Flush_Done(Flush_Done)
  );

  // One cycle: check FIFO invariants, log clears/pops, then let the bank react to Clr_Dirty.
  task automatic tick();
    logic clrNow;
    logic [IW-1:0] selNow;
    checks++;
    if (Out_Valid !== (Buf_Level != 0) || Buf_Level > BD) begin
      errors++;
      $display("[TB] FAIL level_valid: Out_Valid=%0b Buf_Level=%0d", Out_Valid, Buf_Level);
    end
    if (holdPrev) begin
      checks++;
      if (Out_Valid !== 1'b1 || Out_Data !== dataPrev) begin
        errors++;
        $display("[TB] FAIL hold_stable: valid=%0b data=%h required %h", Out_Valid, Out_Data, dataPrev);
      end
    end
    holdPrev = Out_Valid && !Out_Ready && !Rst;
    dataPrev = Out_Data;
    clrNow = Clr_Dirty && !Rst;
    selNow = Reg_Sel;
    if (clrNow) begin
      clrCyc.push_back(cyc);
      clrSel.push_back(int'(selNow));
    end
    if (Out_Valid && Out_Ready && !Rst) popData.push_back(Out_Data);
    @(posedge Clk);
    #1;
    if (clrNow) dirty[selNow] = 1'b0;
    cyc++;
  endtask

  task automatic doReset();
    Rst = 1'b1; Start = 1'b0; Pwr_off = 1'b0; Out_Ready = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    for (int i = 0; i < NR; i++) bankData[i] = $urandom;
  endtask

  task automatic startRun();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    clrCyc = {};
    clrSel = {};
    popData = {};
    cyc = 0;
  endtask

  task automatic test_reset();
    dirty = '0;
    doReset();
    checks++;
    if (Busy !== 1'b0 || Flush_Done !== 1'b0 || Buf_Level !== '0 || Out_Valid !== 1'b0 ||
        Clr_Dirty !== 1'b0 || Reg_Sel !== '0 || Out_Data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%0b done=%0b lvl=%0d valid=%0b clr=%0b sel=%0d data=%h required all 0",
               Busy, Flush_Done, Buf_Level, Out_Valid, Clr_Dirty, Reg_Sel, Out_Data);
    end
    startRun();
    tick();
    tick();
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_in_wait: got %0b required 1", Busy);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Busy !== 1'b0 || Buf_Level !== '0 || Out_Valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_wait: busy=%0b lvl=%0d valid=%0b required 0", Busy, Buf_Level, Out_Valid);
      end
      tick();
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_busy: got %0b required 1", Busy);
    end
  endtask

  task automatic test_idle_scan();
    int scanLen;
    int period;
    int m;
    doReset();
    dirty = '0;
    Out_Ready = 1'b1;
    startRun();
    scanLen = FAST ? 1 : NR;
    period = 1 + PP + scanLen;
    for (int k = 0; k < 2 * period; k++) begin
      m = k % period;
      checks++;
      if (Busy !== 1'b1 || Clr_Dirty !== 1'b0 || Buf_Level !== '0) begin
        errors++;
        $display("[TB] FAIL idle_scan_k%0d: busy=%0b clr=%0b lvl=%0d required 1/0/0", k, Busy, Clr_Dirty, Buf_Level);
      end
      if (m >= 1 + PP) begin
        checks++;
        if (int'(Reg_Sel) != m - 1 - PP) begin
          errors++;
          $display("[TB] FAIL poll_sel_k%0d: got %0d required %0d", k, Reg_Sel, m - 1 - PP);
        end
      end
      tick();
    end
  endtask

  task automatic test_capture();
    int expCyc[2];
    int expSel[2];
    logic [IW+DW-1:0] expEnt[2];
    doReset();
    dirty = 4'b1010;
    Out_Ready = 1'b1;
    expCyc[0] = FAST ? 6 : 7;  expSel[0] = 1;
    expCyc[1] = FAST ? 8 : 10; expSel[1] = 3;
    expEnt[0] = {IW'(1), bankData[1]};
    expEnt[1] = {IW'(3), bankData[3]};
    startRun();
    repeat (20) tick();
    checks++;
    if (clrCyc.size() != 2 || popData.size() != 2) begin
      errors++;
      $display("[TB] FAIL capture_counts: clears=%0d pops=%0d required 2/2", clrCyc.size(), popData.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= clrCyc.size() || clrCyc[i] != expCyc[i] || clrSel[i] != expSel[i]) begin
        errors++;
        $display("[TB] FAIL capture_clr%0d: got cyc=%0d sel=%0d required cyc=%0d sel=%0d", i,
                 (i < clrCyc.size()) ? clrCyc[i] : -1, (i < clrSel.size()) ? clrSel[i] : -1, expCyc[i], expSel[i]);
      end
      checks++;
      if (i >= popData.size() || popData[i] !== expEnt[i]) begin
        errors++;
        $display("[TB] FAIL capture_data%0d: got %h required %h", i,
                 (i < popData.size()) ? popData[i] : '0, expEnt[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [IW+DW-1:0] expEnt[3];
    doReset();
    dirty = 4'b0111;
    Out_Ready = 1'b0;
    for (int i = 0; i < 3; i++) expEnt[i] = {IW'(i), bankData[i]};
    startRun();
    repeat (12) tick();
    checks++;
    if (Buf_Level !== 2'd2 || Reg_Sel !== 2'd2 || Clr_Dirty !== 1'b0 || Out_Data !== expEnt[0] || dirty !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL stall_full: lvl=%0d sel=%0d clr=%0b data=%h dirty=%b required 2/2/0/%h/0100",
               Buf_Level, Reg_Sel, Clr_Dirty, Out_Data, dirty, expEnt[0]);
    end
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    checks++;
    if (Clr_Dirty !== 1'b1 || Reg_Sel !== 2'd2 || Buf_Level !== 2'd1 || Out_Data !== expEnt[1]) begin
      errors++;
      $display("[TB] FAIL stall_release: clr=%0b sel=%0d lvl=%0d data=%h required 1/2/1/%h",
               Clr_Dirty, Reg_Sel, Buf_Level, Out_Data, expEnt[1]);
    end
    tick();
    checks++;
    if (Buf_Level !== 2'd2) begin
      errors++;
      $display("[TB] FAIL stall_refill: lvl=%0d required 2", Buf_Level);
    end
    Out_Ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (popData.size() != 3 || clrCyc.size() != 3) begin
      errors++;
      $display("[TB] FAIL stall_counts: pops=%0d clears=%0d required 3/3", popData.size(), clrCyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= popData.size() || popData[i] !== expEnt[i]) begin
        errors++;
        $display("[TB] FAIL stall_data%0d: got %h required %h", i, (i < popData.size()) ? popData[i] : '0, expEnt[i]);
      end
    end
  endtask

  task automatic test_last_index();
    int capK;
    doReset();
    dirty = 4'b1000;
    Out_Ready = 1'b1;
    capK = FAST ? 1 + PP + 1 : 1 + PP + NR;
    startRun();
    repeat (capK) tick();
    checks++;
    if (Clr_Dirty !== 1'b1 || Reg_Sel !== 2'd3) begin
      errors++;
      $display("[TB] FAIL last_index_capture: clr=%0b sel=%0d required 1/3 at cycle %0d", Clr_Dirty, Reg_Sel, capK);
    end
    repeat (4) tick();
    checks++;
    if (popData.size() != 1 || popData[0] !== {IW'(3), bankData[3]}) begin
      errors++;
      $display("[TB] FAIL last_index_data: pops=%0d data=%h required 1 entry %h", popData.size(),
               (popData.size() > 0) ? popData[0] : '0, {IW'(3), bankData[3]});
    end
  endtask

  task automatic test_flush();
    int haltK;
    logic [IW+DW-1:0] expEnt[2];
    doReset();
    dirty = 4'b1001;
    Out_Ready = 1'b1;
    expEnt[0] = {IW'(0), bankData[0]};
    expEnt[1] = {IW'(3), bankData[3]};
    haltK = FAST ? 9 : 11;
    startRun();
    tick();
    tick();
    Pwr_off = 1'b1;
    tick();
    Pwr_off = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Reg_Sel !== 2'd0 || Flush_Done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_entry: busy=%0b sel=%0d done=%0b required 1/0/0", Busy, Reg_Sel, Flush_Done);
    end
    for (int k = 0; k < 40 && !Flush_Done; k++) tick();
    checks++;
    if (Flush_Done !== 1'b1 || cyc != haltK) begin
      errors++;
      $display("[TB] FAIL flush_halt: done=%0b at cycle %0d required 1 at %0d", Flush_Done, cyc, haltK);
    end
    checks++;
    if (clrCyc.size() != 2 || clrSel[0] != 0 || clrCyc[0] != 4 || clrSel[1] != 3 || clrCyc[1] != (FAST ? 6 : 8)) begin
      errors++;
      $display("[TB] FAIL flush_clears: count=%0d required 2 at (4,0) and (%0d,3)", clrCyc.size(), FAST ? 6 : 8);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= popData.size() || popData[i] !== expEnt[i]) begin
        errors++;
        $display("[TB] FAIL flush_data%0d: got %h required %h", i, (i < popData.size()) ? popData[i] : '0, expEnt[i]);
      end
    end
    Start = 1'b1;
    repeat (5) tick();
    Start = 1'b0;
    checks++;
    if (Flush_Done !== 1'b1 || Busy !== 1'b0 || Buf_Level !== '0 || dirty !== '0) begin
      errors++;
      $display("[TB] FAIL halt_hold: done=%0b busy=%0b lvl=%0d dirty=%b required 1/0/0/0000", Flush_Done, Busy, Buf_Level, dirty);
    end
  endtask

  task automatic test_pwroff_capture();
    doReset();
    dirty = 4'b0001;
    Out_Ready = 1'b1;
    startRun();
    repeat (1 + PP + 1) tick();
    checks++;
    if (Clr_Dirty !== 1'b1 || Reg_Sel !== 2'd0) begin
      errors++;
      $display("[TB] FAIL pwroff_cap_pre: clr=%0b sel=%0d required 1/0", Clr_Dirty, Reg_Sel);
    end
    Pwr_off = 1'b1;
    tick();
    Pwr_off = 1'b0;
    for (int k = 0; k < 40 && !Flush_Done; k++) tick();
    checks++;
    if (Flush_Done !== 1'b1 || clrCyc.size() != 1 || popData.size() != 1 || popData[0] !== {IW'(0), bankData[0]}) begin
      errors++;
      $display("[TB] FAIL pwroff_capture: done=%0b clears=%0d pops=%0d first=%h required 1/1/1/%h", Flush_Done,
               clrCyc.size(), popData.size(), (popData.size() > 0) ? popData[0] : '0, {IW'(0), bankData[0]});
    end
  endtask

  // Model: every initially dirty register is delivered exactly once, in ascending index order.
  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      logic [NR-1:0] initDirty;
      logic [IW+DW-1:0] expQ[$];
      bit usePwr;
      bit done;
      int pwrAt;
      doReset();
      initDirty = NR'($urandom_range(1, 15));
      dirty = initDirty;
      usePwr = (r % 2) == 1;
      pwrAt = $urandom_range(1, 14);
      expQ = {};
      for (int i = 0; i < NR; i++) if (initDirty[i]) expQ.push_back({IW'(i), bankData[i]});
      startRun();
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
        Out_Ready = ($urandom_range(0, 2) != 0);
        Pwr_off = usePwr && (cyc == pwrAt);
        tick();
        if (usePwr) done = Flush_Done;
        else done = (dirty == '0) && (Buf_Level == '0);
      end
      Pwr_off = 1'b0;
      Out_Ready = 1'b0;
      checks++;
      if (!done || dirty !== '0) begin
        errors++;
        $display("[TB] FAIL rnd%0d_complete: done=%0b dirty=%b required 1/0000", r, done, dirty);
      end
      checks++;
      if (popData.size() != expQ.size()) begin
        errors++;
        $display("[TB] FAIL rnd%0d_count: pops=%0d required %0d", r, popData.size(), expQ.size());
      end
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (i >= popData.size() || popData[i] !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL rnd%0d_data%0d: got %h required %h", r, i, (i < popData.size()) ? popData[i] : '0, expQ[i]);
        end
      end
    end
  endtask

  initial begin
    dirty = '0;
    for (int i = 0; i < NR; i++) bankData[i] = '0;
    Rst = 1'b1; Start = 1'b0; Pwr_off = 1'b0; Out_Ready = 1'b0;
    test_reset();
    test_idle_scan();
    test_capture();
    test_stall();
    test_last_index();
    test_flush();
    test_pwroff_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/pcu_backup_ctrl.md
Name: pcu_backup_ctrl

Overview:
Parametrised power-control unit. It periodically scans a bank of NUM_REGS dirty-tracked registers and captures each dirty one as {index, data} into an internal BUF_DEPTH-entry FIFO. The FIFO drains to the non-volatile store over a valid/ready port. On Pwr_off it performs an emergency full-bank flush instead of dropping to idle. It sits between the register-wrapper bank and the NVM write interface.

Parameters:
NUM_REGS, 16, number of tracked registers (>=2)
DATA_W, 32, register data width
BUF_DEPTH, 8, FIFO entries (>=2, power of two)
POLL_PERIOD, 1000, WAIT length in cycles between scans (>=1)
IDX_W, $clog2(NUM_REGS), derived index width
LVL_W, $clog2(BUF_DEPTH+1), derived level width

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous active-high reset, highest priority
Start  in  1  leave IDLE and begin periodic backup
Pwr_off  in  1  level, sampled synchronously; triggers emergency flush
Reg_Dirty  in  NUM_REGS  per-register dirty flags
Reg_Sel  out  IDX_W  register index currently addressed
Reg_Data  in  DATA_W  data of register Reg_Sel (combinational from the bank)
Clr_Dirty  out  1  one-cycle pulse: clear dirty flag of Reg_Sel
Out_Valid  out  1  FIFO head valid
Out_Data  out  IDX_W+DATA_W  FIFO head {index, data}
Out_Ready  in  1  consumer accepts head when Out_Valid and Out_Ready are both high
Buf_Level  out  LVL_W  FIFO occupancy
Busy  out  1  high in every state except IDLE and HALT
Flush_Done  out  1  high in HALT

Behaviour:
- Reset (sync, Rst=1): State=IDLE; idx=0; timer=0; FIFO empty. All outputs 0 except Reg_Sel=0.
- Priority each cycle: Rst > Pwr_off entry > normal transition.
- States: IDLE, ARM, WAIT, POLL, CAPTURE, FLUSH, FCAPT, DRAIN, HALT.
- IDLE: if Start, go to ARM.
- ARM: timer=0, idx=0. Stay while FIFO full; otherwise go to WAIT.
- WAIT: timer increments each cycle. When timer==POLL_PERIOD-1, go to POLL. WAIT therefore lasts exactly POLL_PERIOD cycles.
- POLL: Reg_Sel=idx, one index per cycle.
  - Reg_Dirty[idx]=1: go to CAPTURE.
  - Else if idx==NUM_REGS-1: go to ARM.
  - Else: idx+1, stay in POLL.
- CAPTURE, FIFO not full: push {idx, Reg_Data}; pulse Clr_Dirty with Reg_Sel=idx. Then go to ARM if idx is last, else idx+1 and back to POLL.
- CAPTURE, FIFO full: stall with no push and no Clr_Dirty. No entry is ever dropped.
- Pwr_off=1 in IDLE, ARM, WAIT, POLL or CAPTURE: go to FLUSH with idx=0 the next cycle. A CAPTURE push committed in that same cycle still completes.
- FLUSH and FCAPT: same scan as POLL and CAPTURE (same stall-on-full rule) with no timer. After the last index, go to DRAIN.
- Pwr_off deasserting during FLUSH, FCAPT or DRAIN is ignored.
- DRAIN: wait until Buf_Level==0, then go to HALT. HALT holds until Rst; Start is ignored.
- FIFO:
  - Pop on Out_Valid & Out_Ready.
  - Push allowed only when not full at the start of the cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves Buf_Level unchanged.
  - Pop on empty is impossible (Out_Valid=0).
  - Pointers wrap modulo BUF_DEPTH.
  - Out_Data is registered and stable while Out_Valid=1 and Out_Ready=0.
- A dirty flag rising after its index has been scanned is picked up on the next scan.

Optional Feature:
PCU_FASTSCAN_EN
- Defined: POLL and FLUSH use a priority encoder over Reg_Dirty masked to indices >= idx. They jump directly to the lowest dirty index (entering CAPTURE/FCAPT next cycle). If none is dirty, POLL goes to ARM and FLUSH goes to DRAIN in one cycle.
- Undefined: linear scan, one index per cycle, as above.

Test Plan:
All scenarios use NUM_REGS=4, BUF_DEPTH=2, POLL_PERIOD=4.
- Rst mid-WAIT, then released -> IDLE; Busy=0; Buf_Level=0; Out_Valid=0; Start needed to resume.
- Start, Reg_Dirty=4'b0000 -> ARM, 4 WAIT cycles, POLL idx 0..3 (linear), back to ARM; no Clr_Dirty and no push.
- Reg_Dirty=4'b1010, Out_Ready=1 -> entries {1,D1} then {3,D3} on Out_Data. Clr_Dirty pulses with Reg_Sel=1 and then Reg_Sel=3.
- Reg_Dirty=4'b0111, Out_Ready=0 -> two pushes, then stall in CAPTURE at idx=2 with Buf_Level=2. Raising Out_Ready for 1 cycle -> index 2 captured the next cycle.
- Pwr_off pulse during WAIT with Reg_Dirty=4'b1001, Out_Ready=1 -> FLUSH captures idx 0 and 3, DRAIN, HALT. Flush_Done=1 and Busy=0; Start afterward is ignored.
- With PCU_FASTSCAN_EN, Reg_Dirty=4'b1000 -> POLL to CAPTURE at idx=3 within 1 cycle of WAIT end.
